// File: rtl/reg_bus_master.sv
// ---------------------------------------------------------------------------
// reg_bus_master
// Bridges a Wishbone classic (B4) slave port to a simple register-bus
// initiator for one peripheral register block. The register-bus request is
// held until the responder pulses reg_ack or until a bounded number of
// request cycles has elapsed. A timeout ends the Wishbone cycle with
// wbs_err_o, so a hung peripheral cannot stall the CPU.
//
// Parameters
//   AW        reg_addr width; reg_addr = wbs_adr_i[AW+1:2] (word address)
//   TMO_CYC   reg_cs cycles waited for reg_ack before timing out (>= 1)
//   ERR_DATA  wbs_dat_o value returned on a read timeout
//
// Ports
//   mclk, h_reset_n      clock, asynchronous active-low reset
//   wbs_cyc_i/stb_i/we_i Wishbone cycle, strobe and write enable
//   wbs_adr_i/dat_i/sel_i Wishbone byte address, write data, byte selects
//   wbs_dat_o            read data (reg_rdata, ERR_DATA or 0)
//   wbs_ack_o/err_o      one-cycle termination pulses, mutually exclusive
//   reg_cs/wr/addr/wdata/be  register-bus request, stable while reg_cs=1
//   reg_rdata, reg_ack   responder read data and one-cycle acknowledge
// ---------------------------------------------------------------------------
module reg_bus_master #(
  parameter int unsigned AW       = 2,
  parameter logic [15:0] TMO_CYC  = 16'd255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic          mclk,
  input  logic          h_reset_n,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  input  logic [3:0]    wbs_sel_i,
  output logic [31:0]   wbs_dat_o,
  output logic          wbs_ack_o,
  output logic          wbs_err_o,
  output logic          reg_cs,
  output logic          reg_wr,
  output logic [AW-1:0] reg_addr,
  output logic [31:0]   reg_wdata,
  output logic [3:0]    reg_be,
  input  logic [31:0]   reg_rdata,
  input  logic          reg_ack
);

  localparam int unsigned CNT_W = $clog2(32'(TMO_CYC) + 32'd1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TMO_CYC - 16'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             drop_r, drop_s;     // master abandoned the WB cycle mid-request
  logic             keep_s;
  logic             reg_cs_s, reg_wr_s, ack_s, err_s;
  logic [AW-1:0]    reg_addr_s;
  logic [31:0]      reg_wdata_s, dat_s;
  logic [3:0]       reg_be_s;
  logic             unused_s;

  // Byte-lane and upper address bits do not select a register.
  assign unused_s = ^{wbs_adr_i[31:AW+2], wbs_adr_i[1:0]};

  // A termination is reported only if the master still owns the cycle.
  assign keep_s = wbs_cyc_i & ~drop_r;

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    drop_s      = drop_r;
    reg_cs_s    = reg_cs;
    reg_wr_s    = reg_wr;
    reg_addr_s  = reg_addr;
    reg_wdata_s = reg_wdata;
    reg_be_s    = reg_be;
    ack_s       = 1'b0;
    err_s       = 1'b0;
    dat_s       = wbs_dat_o;
    case (state_r)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          reg_cs_s    = 1'b1;
          reg_wr_s    = wbs_we_i;
          reg_addr_s  = wbs_adr_i[AW+1:2];
          reg_wdata_s = wbs_dat_i;
          reg_be_s    = wbs_sel_i;
          cnt_s       = '0;
          drop_s      = 1'b0;
          state_s     = ST_REQ;
        end else begin
          reg_cs_s = 1'b0;
        end
      end
      ST_REQ: begin
        if (!wbs_cyc_i) begin
          drop_s = 1'b1;
        end else begin
          drop_s = drop_r;
        end
        // An ack on the terminal-count cycle takes priority over the timeout.
        if (reg_ack) begin
          reg_cs_s = 1'b0;
          ack_s    = keep_s;
          dat_s    = reg_wr ? 32'd0 : reg_rdata;
          state_s  = ST_RESP;
        end else if (cnt_r == CNT_TERM) begin
          reg_cs_s = 1'b0;
          err_s    = keep_s;
          dat_s    = reg_wr ? 32'd0 : ERR_DATA;
          state_s  = ST_RESP;
        end else begin
          cnt_s = cnt_r + CNT_W'(1'b1);
        end
      end
      ST_RESP: begin
        // One quiet cycle lets the responder's ack clear before a new request.
        reg_cs_s = 1'b0;
        state_s  = ST_IDLE;
      end
      default: begin
        reg_cs_s = 1'b0;
        cnt_s    = '0;
        state_s  = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      drop_r    <= 1'b0;
      reg_cs    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= 32'd0;
      reg_be    <= 4'd0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      drop_r    <= drop_s;
      reg_cs    <= reg_cs_s;
      reg_wr    <= reg_wr_s;
      reg_addr  <= reg_addr_s;
      reg_wdata <= reg_wdata_s;
      reg_be    <= reg_be_s;
      wbs_ack_o <= ack_s;
      wbs_err_o <= err_s;
      wbs_dat_o <= dat_s;
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// ---------------------------------------------------------------------------
// tb_reg_bus_master
// Drives Wishbone transactions and plays the register-bus responder. For each
// transaction a timeline of expected reg_cs / wbs_ack_o / wbs_err_o /
// wbs_dat_o values (indexed by clock cycle) is derived from the responder
// latency, the timeout limit and whether the master abandons the cycle. A
// compare process checks the DUT against that timeline on every cycle.
// Directed cases add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_reg_bus_master;

  localparam int          AW       = 2;
  localparam int          TMO      = 4;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;
  localparam int          DEPTH    = 8192;

  logic          mclk;
  logic          h_reset_n;
  logic          wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [31:0]   wbs_adr_i, wbs_dat_i;
  logic [3:0]    wbs_sel_i;
  logic [31:0]   wbs_dat_o;
  logic          wbs_ack_o, wbs_err_o;
  logic          reg_cs, reg_wr;
  logic [AW-1:0] reg_addr;
  logic [31:0]   reg_wdata;
  logic [3:0]    reg_be;
  logic [31:0]   reg_rdata;
  logic          reg_ack;

  reg_bus_master #(.AW(AW), .TMO_CYC(16'(TMO)), .ERR_DATA(ERR_DATA)) dut (
    .mclk(mclk), .h_reset_n(h_reset_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_be(reg_be),
    .reg_rdata(reg_rdata), .reg_ack(reg_ack)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  bit chk_en = 1'b0;

  // Expected outputs after clock edge i.
  bit          exp_cs  [DEPTH];
  bit          exp_ack [DEPTH];
  bit          exp_err [DEPTH];
  logic [31:0] exp_dat [DEPTH];

  // Request currently expected on the register bus.
  bit          cur_we;
  logic [31:0] cur_adr, cur_dat;
  logic [3:0]  cur_sel;

  // Observation counters for the directed literal checks.
  int          mon_cs, mon_ack, mon_err;
  logic [31:0] mon_dat, mon_addr, mon_wr, mon_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  always @(posedge mclk) cyc_cnt <= cyc_cnt + 1;

  // Per-cycle comparison against the timeline, plus observation counters.
  always @(negedge mclk) begin
    if (chk_en && cyc_cnt < DEPTH) begin
      chk("reg_cs", 32'(reg_cs), 32'(exp_cs[cyc_cnt]));
      chk("wbs_ack_o", 32'(wbs_ack_o), 32'(exp_ack[cyc_cnt]));
      chk("wbs_err_o", 32'(wbs_err_o), 32'(exp_err[cyc_cnt]));
      if (exp_cs[cyc_cnt]) begin
        chk("reg_wr", 32'(reg_wr), 32'(cur_we));
        chk("reg_addr", 32'(reg_addr), 32'(cur_adr[AW+1:2]));
        chk("reg_wdata", reg_wdata, cur_dat);
        chk("reg_be", 32'(reg_be), 32'(cur_sel));
      end
      if (exp_ack[cyc_cnt] || exp_err[cyc_cnt]) begin
        chk("wbs_dat_o", wbs_dat_o, exp_dat[cyc_cnt]);
      end
    end
    if (reg_cs) begin
      mon_cs++;
      mon_addr = 32'(reg_addr);
      mon_wr   = 32'(reg_wr);
      mon_be   = 32'(reg_be);
    end
    if (wbs_ack_o) begin
      mon_ack++;
      mon_dat = wbs_dat_o;
    end
    if (wbs_err_o) begin
      mon_err++;
      mon_dat = wbs_dat_o;
    end
  end

  task automatic clr_mon();
    mon_cs  = 0;
    mon_ack = 0;
    mon_err = 0;
    mon_dat = 32'hFFFF_FFFF;
  endtask

  // One WB transaction; called right after a negedge with the DUT idle.
  // lat >= TMO means the responder never acks; drop_at >= 0 drops wbs_cyc_i
  // that many cycles after reg_cs rises; stray pulses reg_ack during RESP.
  task automatic run_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] rdata,
                         input int lat, input int drop_at, input bit stray);
    int  n, d;
    bit  acked, keep;
    n     = cyc_cnt + 1;
    acked = (lat < TMO);
    d     = acked ? lat + 1 : TMO;
    keep  = (drop_at < 0);
    cur_we = we; cur_adr = adr; cur_dat = dat; cur_sel = sel;
    for (int i = n; i < n + d; i++) exp_cs[i] = 1'b1;
    if (keep) begin
      if (acked) exp_ack[n + d] = 1'b1;
      else       exp_err[n + d] = 1'b1;
      exp_dat[n + d] = we ? 32'd0 : (acked ? rdata : ERR_DATA);
    end
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    reg_ack   = 1'b0;
    for (int t = n; t <= n + d; t++) begin
      @(negedge mclk);
      reg_ack   = acked && (t == n + lat);
      reg_rdata = reg_ack ? rdata : $urandom();
      if ((drop_at >= 0 && t >= n + drop_at) || t == n + d) begin
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
      end
      if (t == n + d) reg_ack = stray;
    end
    @(negedge mclk);
    reg_ack = 1'b0;
  endtask

  // Idle cycles with random stray acks that must be ignored.
  task automatic idle_gap(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge mclk);
      reg_ack   = 1'($urandom_range(0, 1));
      reg_rdata = $urandom();
    end
  endtask

  // Async reset while reg_cs is high, then a normal read.
  task automatic reset_mid_txn();
    int n;
    n = cyc_cnt + 1;
    cur_we = 1'b0; cur_adr = 32'h0000_000C; cur_dat = 32'h0; cur_sel = 4'hF;
    exp_cs[n] = 1'b1; exp_cs[n + 1] = 1'b1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = cur_adr; wbs_dat_i = cur_dat; wbs_sel_i = cur_sel;
    reg_ack = 1'b0;
    @(negedge mclk);
    @(negedge mclk);
    #2 h_reset_n = 1'b0;
    #1;
    chk("rst_reg_cs", 32'(reg_cs), 32'd0);
    chk("rst_ack", 32'(wbs_ack_o), 32'd0);
    chk("rst_err", 32'(wbs_err_o), 32'd0);
    chk("rst_dat", wbs_dat_o, 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge mclk);
    @(negedge mclk);
    h_reset_n = 1'b1;
    @(negedge mclk);
    clr_mon();
    run_txn(1'b0, 32'h0000_0008, 32'h0, 4'hF, 32'h0BAD_F00D, 1, -1, 1'b0);
    chk("post_rst_ack", 32'(mon_ack), 32'd1);
    chk("post_rst_dat", mon_dat, 32'h0BAD_F00D);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, d, drop_at;
    h_reset_n = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_adr_i = 32'd0; wbs_dat_i = 32'd0; wbs_sel_i = 4'd0;
    reg_rdata = 32'd0; reg_ack = 1'b0;
    clr_mon();
    repeat (3) @(negedge mclk);
    chk("reset_reg_cs", 32'(reg_cs), 32'd0);
    chk("reset_ack", 32'(wbs_ack_o), 32'd0);
    chk("reset_err", 32'(wbs_err_o), 32'd0);
    chk("reset_dat", wbs_dat_o, 32'd0);
    h_reset_n = 1'b1;
    @(negedge mclk);
    chk_en = 1'b1;

    // Write, ack after 2 cycles: reg_cs high 3 cycles.
    clr_mon();
    run_txn(1'b1, 32'h0000_0004, 32'h0001_2345, 4'hF, 32'h0, 2, -1, 1'b0);
    chk("wr_cs_cycles", 32'(mon_cs), 32'd3);
    chk("wr_ack_cnt", 32'(mon_ack), 32'd1);
    chk("wr_err_cnt", 32'(mon_err), 32'd0);
    chk("wr_addr", mon_addr, 32'd1);
    chk("wr_wr", mon_wr, 32'd1);
    chk("wr_be", mon_be, 32'hF);
    chk("wr_dat", mon_dat, 32'd0);

    // Read, ack in the first reg_cs cycle.
    clr_mon();
    run_txn(1'b0, 32'h0000_0008, 32'h0, 4'hF, 32'hA5A5_0003, 0, -1, 1'b1);
    chk("rd0_cs_cycles", 32'(mon_cs), 32'd1);
    chk("rd0_ack_cnt", 32'(mon_ack), 32'd1);
    chk("rd0_dat", mon_dat, 32'hA5A5_0003);
    chk("rd0_addr", mon_addr, 32'd2);

    // Read timeout.
    clr_mon();
    run_txn(1'b0, 32'h0000_000C, 32'h0, 4'hF, 32'h0, TMO, -1, 1'b0);
    chk("tmo_cs_cycles", 32'(mon_cs), 32'd4);
    chk("tmo_err_cnt", 32'(mon_err), 32'd1);
    chk("tmo_ack_cnt", 32'(mon_ack), 32'd0);
    chk("tmo_dat", mon_dat, 32'hDEAD_BEEF);

    // Ack on the terminal-count cycle wins.
    clr_mon();
    run_txn(1'b0, 32'h0000_0000, 32'h0, 4'h3, 32'h1357_9BDF, TMO - 1, -1, 1'b0);
    chk("term_cs_cycles", 32'(mon_cs), 32'd4);
    chk("term_ack_cnt", 32'(mon_ack), 32'd1);
    chk("term_err_cnt", 32'(mon_err), 32'd0);
    chk("term_dat", mon_dat, 32'h1357_9BDF);

    // Master drops wbs_cyc_i one cycle after reg_cs rises.
    clr_mon();
    run_txn(1'b0, 32'h0000_0004, 32'h0, 4'hF, 32'h2222_3333, 2, 1, 1'b0);
    chk("drop_cs_cycles", 32'(mon_cs), 32'd3);
    chk("drop_ack_cnt", 32'(mon_ack), 32'd0);
    chk("drop_err_cnt", 32'(mon_err), 32'd0);
    clr_mon();
    run_txn(1'b0, 32'h0000_0008, 32'h0, 4'hF, 32'h4444_5555, 1, -1, 1'b0);
    chk("after_drop_ack", 32'(mon_ack), 32'd1);
    chk("after_drop_dat", mon_dat, 32'h4444_5555);

    reset_mid_txn();

    // Randomized traffic checked by the per-cycle timeline.
    for (int k = 0; k < 250; k++) begin
      lat = ($urandom_range(0, 9) < 2) ? TMO : int'($urandom_range(0, TMO - 1));
      d   = (lat < TMO) ? lat + 1 : TMO;
      drop_at = ($urandom_range(0, 6) == 0) ? int'($urandom_range(0, d - 1)) : -1;
      run_txn(1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom_range(0, 15)),
              $urandom(), lat, drop_at, 1'($urandom_range(0, 1)));
      idle_gap(int'($urandom_range(0, 2)));
    end
    @(negedge mclk);
    reg_ack = 1'b0;
    repeat (3) @(negedge mclk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
